// File: rtl/tick_logic_unit.sv
// Two-stage prescaler driving a run-time selectable WIDTH-bit logic operator.
// The result register loads only on second-stage ticks and flags each load with po_valid.
module tick_logic_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV1  = 4,
  parameter int unsigned DIV2  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pi_en,
  input  logic             pi_clr,
  input  logic [1:0]       pi_mode,
  input  logic [WIDTH-1:0] pi_a,
  input  logic [WIDTH-1:0] pi_b,
  output logic             po_tick,
  output logic [WIDTH-1:0] po_c,
  output logic             po_valid
);

  localparam int unsigned CNT1_W = $clog2(DIV1);
  localparam int unsigned CNT2_W = $clog2(DIV2);
  localparam logic [CNT1_W-1:0] CNT1_LAST = CNT1_W'(DIV1 - 1);
  localparam logic [CNT2_W-1:0] CNT2_LAST = CNT2_W'(DIV2 - 1);

  logic [CNT1_W-1:0] cnt1_q, cnt1_d;
  logic [CNT2_W-1:0] cnt2_q, cnt2_d;
  logic              flag1_q, flag1_d;
  logic              tick_q, tick_d;
  logic [WIDTH-1:0]  c_q, c_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  op_res;

  // Operator selected by pi_mode, evaluated on the current operands.
  always_comb begin
    op_res = '0;
    case (pi_mode)
      2'd0:    op_res = pi_a & pi_b;
      2'd1:    op_res = pi_a | pi_b;
      2'd2:    op_res = pi_a ^ pi_b;
      default: op_res = ~(pi_a & pi_b);
    endcase
  end

  // Stage 1: count enabled clocks, pulse flag1 on the wrap. Clear beats enable and wrap.
  always_comb begin
    cnt1_d  = cnt1_q;
    flag1_d = 1'b0;
    if (pi_clr) begin
      cnt1_d = '0;
    end else if (pi_en) begin
      flag1_d = (cnt1_q == CNT1_LAST);
      cnt1_d  = flag1_d ? '0 : cnt1_q + CNT1_W'(1);
    end
  end

  // Stage 2: count flag1 pulses regardless of pi_en, so an in-flight flag still lands.
  always_comb begin
    cnt2_d = cnt2_q;
    tick_d = 1'b0;
    if (pi_clr) begin
      cnt2_d = '0;
    end else if (flag1_q) begin
      tick_d = (cnt2_q == CNT2_LAST);
      cnt2_d = tick_d ? '0 : cnt2_q + CNT2_W'(1);
    end
  end

  // Output stage: load the operator result on a tick; clear does not touch this stage.
  always_comb begin
    c_d     = c_q;
    valid_d = tick_q;
    if (tick_q) begin
      c_d = op_res;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      flag1_q <= 1'b0;
      tick_q  <= 1'b0;
      c_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      flag1_q <= flag1_d;
      tick_q  <= tick_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

  assign po_tick  = tick_q;
  assign po_c     = c_q;
  assign po_valid = valid_q;

endmodule

// File: tb/tb_tick_logic_unit.sv
// Bench for tick_logic_unit: directed timing scenarios plus randomized traffic,
// checked every cycle against a model that counts enabled clocks since the last clear.
module tb_tick_logic_unit;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIV1   = 4;
  localparam int unsigned DIV2   = 16;
  localparam int unsigned PERIOD = DIV1 * DIV2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pi_en = 1'b0;
  logic             pi_clr = 1'b0;
  logic [1:0]       pi_mode = 2'd0;
  logic [WIDTH-1:0] pi_a = '0;
  logic [WIDTH-1:0] pi_b = '0;
  logic             po_tick;
  logic [WIDTH-1:0] po_c;
  logic             po_valid;

  int n_checks = 0;
  int n_fail   = 0;

  tick_logic_unit #(
    .WIDTH (WIDTH),
    .DIV1  (DIV1),
    .DIV2  (DIV2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pi_en    (pi_en),
    .pi_clr   (pi_clr),
    .pi_mode  (pi_mode),
    .pi_a     (pi_a),
    .pi_b     (pi_b),
    .po_tick  (po_tick),
    .po_c     (po_c),
    .po_valid (po_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] op(input logic [1:0] m, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    case (m)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: m_n counts enabled, uncleared clocks since reset/clear. A flag is raised on
  // every multiple of DIV1, and the flag carrying a multiple of DIV1*DIV2 becomes a tick.
  int unsigned      m_n;
  int unsigned      m_flag_n;
  bit               m_flag;
  bit               m_tick;
  bit               m_valid;
  logic [WIDTH-1:0] m_c;
  bit               new_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_flag_n = 0; m_flag = 0; m_tick = 0; m_valid = 0; m_c = '0;
    end else begin
      if (m_tick) begin
        m_c     = op(pi_mode, pi_a, pi_b);
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      new_tick = !pi_clr && m_flag && (m_flag_n % PERIOD == 0);
      if (pi_clr) begin
        m_n    = 0;
        m_flag = 0;
      end else if (pi_en) begin
        m_n++;
        m_flag   = (m_n % DIV1 == 0);
        m_flag_n = m_n;
      end else begin
        m_flag = 0;
      end
      m_tick = new_tick;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit prev_valid = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("tick", 32'(po_tick), 32'(m_tick));
      check("c", 32'(po_c), 32'(m_c));
      check("valid", 32'(po_valid), 32'(m_valid));
      check("valid_width", 32'(po_valid & prev_valid), 32'd0);
      prev_valid = po_valid;
    end else begin
      prev_valid = 0;
    end
  end

  // Advance n rising edges, then settle on the following falling edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Reset with the given operands; returns on the negedge of release, so edge 1 is next.
  task automatic do_reset(input logic [1:0] m, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    @(negedge clk);
    rst_n = 1'b0; pi_en = 1'b1; pi_clr = 1'b0; pi_mode = m; pi_a = a; pi_b = b;
    repeat (2) @(negedge clk);
    check("rst_tick", 32'(po_tick), 32'd0);
    check("rst_c", 32'(po_c), 32'd0);
    check("rst_valid", 32'(po_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  logic [WIDTH-1:0] sweep_exp [4];

  initial begin
    sweep_exp[0] = 8'h05; sweep_exp[1] = 8'hAF; sweep_exp[2] = 8'hAA; sweep_exp[3] = 8'hFA;

    // Basic timing with AND.
    do_reset(2'd0, 8'hF0, 8'h3C);
    wait_edges(64);
    check("s1_tick_e64", 32'(po_tick), 32'd0);
    wait_edges(1);
    check("s1_tick_e65", 32'(po_tick), 32'd1);
    check("s1_valid_e65", 32'(po_valid), 32'd0);
    wait_edges(1);
    check("s1_c_e66", 32'(po_c), 32'h30);
    check("s1_valid_e66", 32'(po_valid), 32'd1);
    wait_edges(63);
    check("s1_valid_e129", 32'(po_valid), 32'd0);
    wait_edges(1);
    check("s1_valid_e130", 32'(po_valid), 32'd1);

    // Asynchronous reset mid-period while po_c holds a result.
    wait_edges(20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_c", 32'(po_c), 32'd0);
    check("async_tick", 32'(po_tick), 32'd0);
    check("async_valid", 32'(po_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(65);
    check("rr_tick_e65", 32'(po_tick), 32'd1);
    wait_edges(1);
    check("rr_c_e66", 32'(po_c), 32'h30);
    check("rr_valid_e66", 32'(po_valid), 32'd1);

    // Mode sweep, mode changed between ticks.
    do_reset(2'd0, 8'hA5, 8'h0F);
    wait_edges(66);
    check("sweep_and", 32'(po_c), 32'(sweep_exp[0]));
    for (int k = 1; k < 4; k++) begin
      pi_mode = 2'(k);
      wait_edges(PERIOD);
      check("sweep_mode", 32'(po_c), 32'(sweep_exp[k]));
      check("sweep_valid", 32'(po_valid), 32'd1);
    end

    // Enable held low for edges 30..39.
    do_reset(2'd1, 8'h12, 8'h40);
    wait_edges(29);
    pi_en = 1'b0;
    wait_edges(10);
    check("hold_c", 32'(po_c), 32'd0);
    pi_en = 1'b1;
    wait_edges(36);
    check("hold_valid_e75", 32'(po_valid), 32'd0);
    wait_edges(1);
    check("hold_valid_e76", 32'(po_valid), 32'd1);
    check("hold_c_e76", 32'(po_c), 32'h52);

    // Clear pulsed at edge 40.
    do_reset(2'd2, 8'h33, 8'h0F);
    wait_edges(39);
    pi_clr = 1'b1;
    wait_edges(1);
    pi_clr = 1'b0;
    wait_edges(65);
    check("clr_valid_e105", 32'(po_valid), 32'd0);
    check("clr_c_e105", 32'(po_c), 32'd0);
    wait_edges(1);
    check("clr_valid_e106", 32'(po_valid), 32'd1);
    check("clr_c_e106", 32'(po_c), 32'h3C);

    // Randomized traffic: operands and mode change every clock, occasional hold/clear.
    do_reset(2'd0, 8'h00, 8'h00);
    for (int i = 0; i < 4000; i++) begin
      pi_en   = ($urandom_range(0, 7) != 0);
      pi_clr  = ($urandom_range(0, 99) == 0);
      pi_mode = 2'($urandom_range(0, 3));
      pi_a    = WIDTH'($urandom);
      pi_b    = WIDTH'($urandom);
      wait_edges(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
